digital_tube_ctrl: RTL

- Memory-mapped, parametrised multi-group 7-segment display controller on the CPU peripheral bus.
- Time-multiplexes GROUPS independent digit groups of DIGITS_PER_GROUP digits each, all groups scanned in lockstep.
- Adds per-digit blanking, per-digit decimal points, a global enable and 16-level PWM brightness.
- Register file is word-addressed with byte enables.

---
 rtl/digital_tube_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/digital_tube_ctrl.sv
// Multi-group 7-segment display controller with a 4-word bus register window.
// Groups are scanned in lockstep; each digit has blanking and a decimal point,
// and a global enable plus 16-level PWM gate all digit selects.
module digital_tube_ctrl #(
    parameter logic [31:0] BASE_ADDR        = 32'h00007f50,
    parameter int unsigned GROUPS           = 2,
    parameter int unsigned DIGITS_PER_GROUP = 4,
    parameter int unsigned SCAN_PERIOD      = 25000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [31:0]                          Addr,
    input  logic [3:0]                           ByteEn,
    input  logic [31:0]                          Din,
    output logic [31:0]                          Dout,
    output logic [GROUPS*DIGITS_PER_GROUP-1:0]   sel,
    output logic [8*GROUPS-1:0]                  seg
);

    localparam int unsigned D  = DIGITS_PER_GROUP;
    localparam int unsigned N  = GROUPS * DIGITS_PER_GROUP;
    localparam int unsigned SW = (D > 1) ? $clog2(D) : 1;

    // Storage masks: bits belonging to nonexistent digits are never kept.
    localparam logic [63:0] DATA_MASK = (N >= 16) ? '1 : ((64'd1 << (4 * N)) - 64'd1);
    localparam logic [15:0] DIG_MASK  = (N >= 16) ? '1 : 16'((32'd1 << N) - 32'd1);
    localparam logic [31:0] LO_MASK   = DATA_MASK[31:0];
    localparam logic [31:0] HI_MASK   = DATA_MASK[63:32];
    localparam logic [31:0] CTRL_MASK = {7'd0, 1'b1, 4'd0, 4'hF, DIG_MASK};
    localparam logic [31:0] DP_MASK   = {16'd0, DIG_MASK};

    localparam logic [31:0] LO_RST    = 32'h88888888 & LO_MASK;
    localparam logic [31:0] HI_RST    = 32'h88888888 & HI_MASK;
    localparam logic [31:0] CTRL_RST  = 32'h010F0000;
    localparam logic [31:0] DP_RST    = 32'h00000000;

    logic [31:0]   data_lo_q, data_lo_d;
    logic [31:0]   data_hi_q, data_hi_d;
    logic [31:0]   ctrl_q,    ctrl_d;
    logic [31:0]   dp_q,      dp_d;
    logic [31:0]   cnt_q,     cnt_d;
    logic [SW-1:0] slot_q,    slot_d;
    logic [3:0]    pwm_q,     pwm_d;

    logic [31:0] word_addr;
    logic        hit_lo, hit_hi, hit_ctrl, hit_dp, wr_en;
    logic [31:0] be_mask;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] bmask,
                                          input logic [31:0] keep);
        return ((old_v & ~bmask) | (new_v & bmask)) & keep;
    endfunction

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'h81;  4'h1: s = 8'hCF;  4'h2: s = 8'h92;  4'h3: s = 8'h86;
            4'h4: s = 8'hCC;  4'h5: s = 8'hA4;  4'h6: s = 8'hA0;  4'h7: s = 8'h8F;
            4'h8: s = 8'h80;  4'h9: s = 8'h84;  4'hA: s = 8'h88;  4'hB: s = 8'hE0;
            4'hC: s = 8'hB1;  4'hD: s = 8'hC2;  4'hE: s = 8'hB0;  default: s = 8'hB8;
        endcase
        return s;
    endfunction

    assign word_addr = Addr & ~32'h3;
    assign hit_lo    = (word_addr == BASE_ADDR);
    assign hit_hi    = (word_addr == BASE_ADDR + 32'h4);
    assign hit_ctrl  = (word_addr == BASE_ADDR + 32'h8);
    assign hit_dp    = (word_addr == BASE_ADDR + 32'hC);
    assign wr_en     = |ByteEn;
    assign be_mask   = {{8{ByteEn[3]}}, {8{ByteEn[2]}}, {8{ByteEn[1]}}, {8{ByteEn[0]}}};

    // Next-state for the register file and the scan/PWM counters.
    always_comb begin
        data_lo_d = data_lo_q;
        data_hi_d = data_hi_q;
        ctrl_d    = ctrl_q;
        dp_d      = dp_q;
        if (wr_en) begin
            if (hit_lo)   data_lo_d = merge(data_lo_q, Din, be_mask, LO_MASK);
            if (hit_hi)   data_hi_d = merge(data_hi_q, Din, be_mask, HI_MASK);
            if (hit_ctrl) ctrl_d    = merge(ctrl_q,    Din, be_mask, CTRL_MASK);
            if (hit_dp)   dp_d      = merge(dp_q,      Din, be_mask, DP_MASK);
        end

        pwm_d = pwm_q + 4'd1;
        if (cnt_q == SCAN_PERIOD - 1) begin
            cnt_d  = '0;
            slot_d = slot_q + SW'(1);
        end else begin
            cnt_d  = cnt_q + 32'd1;
            slot_d = slot_q;
        end
    end

    // State registers; reset restores defaults and restarts the scan at digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_lo_q <= LO_RST;
            data_hi_q <= HI_RST;
            ctrl_q    <= CTRL_RST;
            dp_q      <= DP_RST;
            cnt_q     <= '0;
            slot_q    <= '0;
            pwm_q     <= '0;
        end else begin
            data_lo_q <= data_lo_d;
            data_hi_q <= data_hi_d;
            ctrl_q    <= ctrl_d;
            dp_q      <= dp_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            pwm_q     <= pwm_d;
        end
    end

    // Read mux: only the four register words decode, everything else reads 0.
    always_comb begin
        Dout = '0;
        if (hit_lo)   Dout = data_lo_q;
        if (hit_hi)   Dout = data_hi_q;
        if (hit_ctrl) Dout = ctrl_q;
        if (hit_dp)   Dout = dp_q;
    end

    // Digit drive: one active digit per group, gated by EN, PWM phase and blanking.
    always_comb begin
        logic [63:0]  data_all;
        logic         on;
        int unsigned  di;
        sel      = '0;
        seg      = '1;
        data_all = {data_hi_q, data_lo_q};
        on       = (pwm_q <= ctrl_q[19:16]);
        for (int unsigned g = 0; g < GROUPS; g++) begin
            di = g * D + 32'(slot_q);
            if (ctrl_q[24] && on && !ctrl_q[di]) begin
                sel[di]        = 1'b1;
                seg[8*g +: 8]  = hex2seg(data_all[4*di +: 4]) & {~dp_q[di], 7'h7F};
            end
        end
    end

endmodule
